// File: rtl/data_mem_responder.sv
// Responder end of the LSU memory interface: word-organised data RAM plus a small MMIO block.
// Optional free-running CYCLE register at MMIO offset 0x10 is built only when DMEM_CYCLE_COUNTER_EN is defined.
module data_mem_responder #(
  parameter logic [31:0] RAM_BASE  = 32'h8010_0000,
  parameter int          RAM_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE = 32'h8020_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wen,
  input  logic [31:0] wdata,
  input  logic [1:0]  mask,
  output logic [31:0] rdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        err_out
);

  // Handshake: none. The responder is always ready; a store commits on the
  // rising edge where wen=1, and rdata is a combinational function of addr.

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;

  localparam logic [9:0] OFF_LED   = 10'h000;
  localparam logic [9:0] OFF_SW    = 10'h001;
  localparam logic [9:0] OFF_CYCLE = 10'h004;
  localparam logic [9:0] OFF_ERR   = 10'h005;

  logic [31:0]   mem_q [RAM_WORDS];
  logic [31:0]   mem_wdata_d;
  logic          mem_we;

  logic [15:0]   led_q, led_d;
  logic [1:0]    err_q, err_d;
  logic [15:0]   sw_meta_q, sw_sync_q;

  logic [31:0]   ram_off;
  logic          ram_hit, mmio_hit;
  logic [AW-1:0] ram_idx;
  logic [1:0]    off;
  logic [9:0]    mmio_word;
  logic          size_ok, mmio_size_ok, mmio_store_ok;
  logic          led_we, err_we;
  logic [1:0]    err_set;
  logic [3:0]    be;
  logic [31:0]   wd_lanes, ram_rd_word, mmio_rd_word, rd_word;

  assign ram_off   = addr - RAM_BASE;
  assign ram_hit   = (ram_off < RAM_BYTES);
  assign ram_idx   = ram_off[AW+1:2];
  assign mmio_hit  = (addr[31:12] == MMIO_BASE[31:12]);
  assign mmio_word = addr[11:2];
  assign off       = addr[1:0];

  always_comb begin
    size_ok  = 1'b0;
    be       = 4'b0000;
    wd_lanes = wdata;
    case (mask)
      2'b00: begin
        size_ok  = 1'b1;
        be       = 4'b0001 << off;
        wd_lanes = {4{wdata[7:0]}};
      end
      2'b01: begin
        size_ok  = ~off[0];
        be       = 4'b0011 << off;
        wd_lanes = {2{wdata[15:0]}};
      end
      2'b10: begin
        size_ok  = (off == 2'b00);
        be       = 4'b1111;
        wd_lanes = wdata;
      end
      default: begin
        size_ok  = 1'b0;
        be       = 4'b0000;
        wd_lanes = wdata;
      end
    endcase
  end

  assign ram_rd_word = mem_q[ram_idx];

  // Byte-lane merge against the current word; untouched lanes keep their contents.
  always_comb begin
    mem_wdata_d = ram_rd_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem_wdata_d[8*i +: 8] = wd_lanes[8*i +: 8];
    end
  end

  assign mem_we        = wen & ram_hit & size_ok;
  assign mmio_size_ok  = (mask == 2'b10) && (off == 2'b00);
  assign mmio_store_ok = wen & mmio_hit & mmio_size_ok;
  assign led_we        = mmio_store_ok & (mmio_word == OFF_LED);
  assign err_we        = mmio_store_ok & (mmio_word == OFF_ERR);

  assign err_set[0] = wen & ((ram_hit & ~size_ok) | (mmio_hit & ~mmio_size_ok));
  assign err_set[1] = wen & ~ram_hit & ~mmio_hit;

  always_comb begin
    led_d = led_q;
    if (led_we) led_d = wdata[15:0];
    // Set is OR'd in after the clear so a simultaneous set wins.
    err_d = (err_q & ~(err_we ? wdata[1:0] : 2'b00)) | err_set;
  end

  // RAM is not reset; holding reset low suppresses any store in flight.
  always_ff @(posedge clock) begin
    if (mem_we && reset) mem_q[ram_idx] <= mem_wdata_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_q     <= '0;
      err_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      err_q     <= err_d;
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_q, cycle_d;
  logic        cyc_we;

  assign cyc_we = mmio_store_ok & (mmio_word == OFF_CYCLE);

  always_comb begin
    cycle_d = cyc_we ? wdata : cycle_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle_q <= '0;
    else        cycle_q <= cycle_d;
  end
`endif

  always_comb begin
    mmio_rd_word = '0;
    case (mmio_word)
      OFF_LED:   mmio_rd_word = {16'd0, led_q};
      OFF_SW:    mmio_rd_word = {16'd0, sw_sync_q};
`ifdef DMEM_CYCLE_COUNTER_EN
      OFF_CYCLE: mmio_rd_word = cycle_q;
`else
      OFF_CYCLE: mmio_rd_word = '0;
`endif
      OFF_ERR:   mmio_rd_word = {30'd0, err_q};
      default:   mmio_rd_word = '0;
    endcase
  end

  always_comb begin
    rd_word = '0;
    if (ram_hit)       rd_word = ram_rd_word;
    else if (mmio_hit) rd_word = mmio_rd_word;
  end

  // Right-justify so the LSU extends from rdata[7:0] / rdata[15:0].
  assign rdata   = rd_word >> {off, 3'b000};
  assign led_out = led_q;
  assign err_out = |err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: reset, lane steering, errors, MMIO, CYCLE and random RAM traffic.
// Expected CYCLE reads follow DMEM_CYCLE_COUNTER_EN the same way the design does.
module tb_data_mem_responder;

  localparam logic [31:0] RB = 32'h8010_0000;
  localparam logic [31:0] MB = 32'h8020_0000;

  logic        clock;
  logic        reset;
  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [1:0]  mask;
  logic [31:0] rdata;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        err_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic [1:0]  m;
    logic        chk;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  data_mem_responder dut (
    .clock   (clock),
    .reset   (reset),
    .addr    (addr),
    .wen     (wen),
    .wdata   (wdata),
    .mask    (mask),
    .rdata   (rdata),
    .sw_in   (sw_in),
    .led_out (led_out),
    .err_out (err_out)
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                              input logic [1:0] m, input logic chk, input logic [31:0] e,
                              input logic [15:0] led, input logic err);
    vec_t v;
    v.a = a; v.w = w; v.d = d; v.m = m; v.chk = chk;
    v.exp_rd = e; v.exp_led = led; v.exp_err = err;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Driver: inputs change just after the falling edge.
  task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [1:0] m);
    @(negedge clock);
    addr = a; wen = w; wdata = d; mask = m;
  endtask

  task automatic expect_rd(input string nm, input logic [31:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Scoreboard: compare rdata mid-cycle against everything queued for it.
  task automatic sample_rd();
    #2;
    while (exp_q.size() > 0) check(name_q.pop_front(), rdata, exp_q.pop_front());
  endtask

  logic [31:0] model [int];
  int          keys_q[$];

  initial begin
    logic [31:0] cyc_exp [3];
    reset = 1'b0;
    sw_in = 16'hA5A5;
    addr  = MB;
    wen   = 1'b1;
    wdata = 32'hFFFF_FFFF;
    mask  = 2'b10;

    // Reset held with an LED store pending: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #2;
      check($sformatf("reset_led%0d", i), {16'd0, led_out}, 32'd0);
      check($sformatf("reset_err%0d", i), {31'd0, err_out}, 32'd0);
      check($sformatf("reset_rd%0d", i), rdata, 32'd0);
    end

    @(negedge clock);
    reset = 1'b1; wen = 1'b0; addr = MB + 32'h10;
    expect_rd("cycle_after_reset", 32'd0);
    sample_rd();
    addr = MB + 32'h4;
    expect_rd("sw_cycle0", 32'd0);
    sample_rd();
    drive(MB + 32'h4, 1'b0, 32'd0, 2'b10);
    expect_rd("sw_cycle1", 32'd0);
    sample_rd();
    drive(MB + 32'h4, 1'b0, 32'd0, 2'b10);
    expect_rd("sw_cycle2", 32'h0000_A5A5);
    sample_rd();

    // Vector table: rdata/led/err visible during the row, before its own edge.
    vecs.push_back(mk(RB,          1, 32'h1122_3344, 2'b10, 0, 32'h0,          16'h0,    0));
    vecs.push_back(mk(RB + 2,      1, 32'h0000_00AB, 2'b00, 1, 32'h0000_1122, 16'h0,    0));
    vecs.push_back(mk(RB,          1, 32'h0000_BEEF, 2'b01, 1, 32'h11AB_3344, 16'h0,    0));
    vecs.push_back(mk(RB,          0, 32'h0,         2'b10, 1, 32'h11AB_BEEF, 16'h0,    0));
    vecs.push_back(mk(RB + 3,      0, 32'h0,         2'b00, 1, 32'h0000_0011, 16'h0,    0));
    vecs.push_back(mk(RB + 2,      0, 32'h0,         2'b01, 1, 32'h0000_11AB, 16'h0,    0));
    vecs.push_back(mk(RB + 1,      1, 32'h0000_BBBB, 2'b01, 1, 32'h0011_ABBE, 16'h0,    0));
    vecs.push_back(mk(RB,          0, 32'h0,         2'b10, 1, 32'h11AB_BEEF, 16'h0,    1));
    vecs.push_back(mk(MB + 32'h14, 0, 32'h0,         2'b10, 1, 32'h0000_0001, 16'h0,    1));
    vecs.push_back(mk(32'h0,       1, 32'h1234_5678, 2'b10, 1, 32'h0,          16'h0,    1));
    vecs.push_back(mk(MB + 32'h14, 0, 32'h0,         2'b10, 1, 32'h0000_0003, 16'h0,    1));
    vecs.push_back(mk(MB + 32'h14, 1, 32'h0000_0001, 2'b10, 1, 32'h0000_0003, 16'h0,    1));
    vecs.push_back(mk(MB + 32'h14, 0, 32'h0,         2'b10, 1, 32'h0000_0002, 16'h0,    1));
    vecs.push_back(mk(MB + 32'h14, 1, 32'h0000_0002, 2'b10, 1, 32'h0000_0002, 16'h0,    1));
    vecs.push_back(mk(MB + 32'h14, 0, 32'h0,         2'b10, 1, 32'h0000_0000, 16'h0,    0));
    vecs.push_back(mk(RB,          1, 32'hFFFF_FFFF, 2'b11, 1, 32'h11AB_BEEF, 16'h0,    0));
    vecs.push_back(mk(RB,          0, 32'h0,         2'b10, 1, 32'h11AB_BEEF, 16'h0,    1));
    vecs.push_back(mk(MB + 32'h14, 1, 32'h0000_0001, 2'b10, 1, 32'h0000_0001, 16'h0,    1));
    vecs.push_back(mk(RB + 32'h4000, 1, 32'h5555_5555, 2'b10, 1, 32'h0,        16'h0,    0));
    vecs.push_back(mk(MB + 32'h14, 0, 32'h0,         2'b10, 1, 32'h0000_0002, 16'h0,    1));
    vecs.push_back(mk(MB + 32'h14, 1, 32'h0000_0002, 2'b10, 1, 32'h0000_0002, 16'h0,    1));
    vecs.push_back(mk(RB + 32'h3FFC, 1, 32'hCAFE_F00D, 2'b10, 0, 32'h0,        16'h0,    0));
    vecs.push_back(mk(RB + 32'h3FFC, 0, 32'h0,       2'b10, 1, 32'hCAFE_F00D, 16'h0,    0));
    vecs.push_back(mk(RB - 4,      1, 32'h7777_7777, 2'b10, 1, 32'h0,          16'h0,    0));
    vecs.push_back(mk(MB + 32'h14, 0, 32'h0,         2'b10, 1, 32'h0000_0002, 16'h0,    1));
    vecs.push_back(mk(MB + 32'h14, 1, 32'h0000_0002, 2'b10, 1, 32'h0000_0002, 16'h0,    1));
    vecs.push_back(mk(RB + 32'h40, 1, 32'h0,         2'b10, 0, 32'h0,          16'h0,    0));
    vecs.push_back(mk(RB + 32'h40, 1, 32'hDEAD_BEEF, 2'b10, 1, 32'h0,          16'h0,    0));
    vecs.push_back(mk(RB + 32'h40, 0, 32'h0,         2'b10, 1, 32'hDEAD_BEEF, 16'h0,    0));
    vecs.push_back(mk(MB,          1, 32'h1234_5678, 2'b10, 1, 32'h0,          16'h0,    0));
    vecs.push_back(mk(MB,          0, 32'h0,         2'b10, 1, 32'h0000_5678, 16'h5678, 0));
    vecs.push_back(mk(MB + 32'h4,  1, 32'hFFFF_FFFF, 2'b10, 1, 32'h0000_A5A5, 16'h5678, 0));
    vecs.push_back(mk(MB + 32'h4,  0, 32'h0,         2'b10, 1, 32'h0000_A5A5, 16'h5678, 0));
    vecs.push_back(mk(MB + 32'h8,  0, 32'h0,         2'b10, 1, 32'h0,          16'h5678, 0));
    vecs.push_back(mk(MB,          1, 32'h0000_1111, 2'b01, 1, 32'h0000_5678, 16'h5678, 0));
    vecs.push_back(mk(MB,          0, 32'h0,         2'b10, 1, 32'h0000_5678, 16'h5678, 1));
    vecs.push_back(mk(MB + 32'h14, 1, 32'h0000_0001, 2'b10, 1, 32'h0000_0001, 16'h5678, 1));
    vecs.push_back(mk(MB + 32'h14, 0, 32'h0,         2'b10, 1, 32'h0000_0000, 16'h5678, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].a, vecs[i].w, vecs[i].d, vecs[i].m);
      if (vecs[i].chk) expect_rd($sformatf("row%0d_rdata", i), vecs[i].exp_rd);
      sample_rd();
      check($sformatf("row%0d_led", i), {16'd0, led_out}, {16'd0, vecs[i].exp_led});
      check($sformatf("row%0d_err", i), {31'd0, err_out}, {31'd0, vecs[i].exp_err});
    end

    // CYCLE load then wrap.
`ifdef DMEM_CYCLE_COUNTER_EN
    cyc_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
`else
    cyc_exp = '{32'h0, 32'h0, 32'h0};
`endif
    drive(MB + 32'h10, 1'b1, 32'hFFFF_FFFE, 2'b10);
    for (int i = 0; i < 3; i++) begin
      drive(MB + 32'h10, 1'b0, 32'h0, 2'b10);
      expect_rd($sformatf("cycle_rd%0d", i), cyc_exp[i]);
      sample_rd();
    end
    check("cycle_no_err", {31'd0, err_out}, 32'd0);

    // Random RAM traffic against a reference word model.
    for (int i = 0; i < 24; i++) begin
      int          idx;
      logic [31:0] d;
      idx = int'($urandom_range(32, 1000));
      d   = $urandom;
      drive(RB + 32'(idx * 4), 1'b1, d, 2'b10);
      model[idx] = d;
      keys_q.push_back(idx);
    end
    for (int i = 0; i < 12; i++) begin
      int          idx;
      int          lane;
      logic [7:0]  b;
      logic [31:0] t;
      idx  = keys_q[$urandom_range(0, keys_q.size() - 1)];
      lane = int'($urandom_range(0, 3));
      b    = 8'($urandom);
      drive(RB + 32'(idx * 4 + lane), 1'b1, {24'd0, b}, 2'b00);
      t = model[idx];
      t[lane*8 +: 8] = b;
      model[idx] = t;
    end
    foreach (model[k]) begin
      drive(RB + 32'(k * 4), 1'b0, 32'h0, 2'b10);
      expect_rd($sformatf("rand_word%0d", k), model[k]);
      sample_rd();
    end
    check("rand_no_err", {31'd0, err_out}, 32'd0);

    // Report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the LSU memory interface: takes the registered `addr`/`wen`/`wdata`/`mask` from the LSU stage and returns `rdata`.
- Decodes the address into a word-organised data RAM and a small MMIO register file (LED output, synchronised switch input, cycle counter, error status).
- Performs byte-lane steering for stores.
- Right-justifies load data so the LSU's sign/zero-extension from `rdata[7:0]`/`rdata[15:0]` is correct.
- Sits between the LSU stage and the board I/O.

## Interface
Parameters:
- `RAM_BASE`, 32'h8010_0000, byte base address of the data RAM.
- `RAM_WORDS`, 4096, RAM depth in 32-bit words; power of two.
- `MMIO_BASE`, 32'h8020_0000, byte base address of the MMIO block (4 KiB window).

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `addr`  in  32  byte address from LSU.
- `wen`  in  1  store strobe; one store per cycle while high.
- `wdata`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `mask`  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- `rdata`  out  32  load data, combinational from `addr`.
- `sw_in`  in  16  asynchronous board switches.
- `led_out`  out  16  LED register.
- `err_out`  out  1  OR of error status bits.

## Operation
- Address decode:
  - RAM hit when `addr` is in [RAM_BASE, RAM_BASE+4*RAM_WORDS).
  - MMIO hit when `addr[31:12]==MMIO_BASE[31:12]`.
  - Anything else is unmapped.
- RAM word index is `(addr-RAM_BASE)>>2`. Byte offset `off=addr[1:0]`.
- Stores (`wen`=1) to RAM:
  - Byte: lane `off` gets `wdata[7:0]`.
  - Half: `off` must be 0 or 2. Lanes off, off+1 get `wdata[15:0]`.
  - Word: `off` must be 0. All lanes get `wdata`.
  - Other lanes are unchanged.
- A misaligned store, a `mask`=11 store, or a store to an unmapped address is suppressed: no state changes except the error status.
- RAM contents are not reset.
- Loads: `rdata` = (selected 32-bit word) >> (8*off), zero-filled at the top. The LSU performs extension. Reads are never flagged as errors because the interface carries no read qualifier.
- Unmapped and reserved MMIO offsets read 0.
- MMIO map (word offsets; stores must be word-size and aligned, otherwise they are errors):
  - 0x00 LED: RW. Bits [15:0] drive `led_out`. Upper bits read 0.
  - 0x04 SW: RO. Returns `{16'd0, sw_sync}`. Writes are ignored and are not an error.
  - 0x10 CYCLE: RW. Free-running 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF→0. A store loads `wdata`.
  - 0x14 ERR: [0] misaligned/reserved-size store, [1] unmapped store. Bits are sticky; writing 1 to a bit clears it.
- `sw_sync` is a two-flop synchronizer on `sw_in`.

## Timing
- Reset values:
  - `led_out`=0, `err_out`=0, CYCLE=0, ERR=0.
  - Synchronizer flops = 0, so the SW register reads 0 until 2 cycles after reset release.
- The reset is asynchronous in assertion. `reset` low mid-store aborts that store; the RAM word may be left unwritten.
- Store latency:
  - A store commits at the rising edge on which `wen`=1.
  - A same-cycle load returns the old value.
  - A load in the following cycle returns the new value.
- `rdata` is purely combinational. There is no ready/valid handshake; the responder is always ready.
- CYCLE:
  - A store in cycle N makes CYCLE=`wdata` in cycle N+1 and `wdata`+1 in N+2. The store wins over the increment.
- ERR:
  - An error set and a W1C clear of the same bit on the same edge: set wins.
  - An error store and an ERR write cannot coincide, since only one store occurs per cycle.
  - A bit set at edge N is visible on `err_out` in cycle N+1.
- The switch synchronizer adds 2 cycles of latency from `sw_in` to `rdata`.

## Configuration
- `DMEM_CYCLE_COUNTER_EN`:
  - Defined: CYCLE exists as described.
  - Undefined: the counter flops are removed, offset 0x10 reads 0, and stores to it are ignored without an error.
- The remainder of the MMIO map is unaffected either way.

## Test plan
- Reset:
  - Hold `reset`=0 with `sw_in`=16'hA5A5 and `wen`=1 at LED.
  - Required: `led_out`=0 and `err_out`=0 throughout.
  - After release: SW reads 0 for 2 cycles, then 0x0000_A5A5.
- Byte/half lanes:
  - Word 0x1122_3344 → RAM_BASE.
  - Byte 0xAB at RAM_BASE+2.
  - Half 0xBEEF at RAM_BASE+0.
  - Required: word read at RAM_BASE = 0x11AB_BEEF, byte read at +3 gives `rdata`=0x0000_0011, half read at +2 gives 0x0000_11AB.
- Misaligned/unmapped:
  - Half store at RAM_BASE+1 → RAM unchanged, ERR=0x1, `err_out`=1.
  - Word store at 0x0000_0000 → ERR=0x3.
  - Write 0x1 to ERR → ERR=0x2.
  - Write 0x2 to ERR → `err_out`=0.
- Cycle counter:
  - Write 0xFFFF_FFFE to CYCLE.
  - Required reads on the next 3 cycles: 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
  - With `DMEM_CYCLE_COUNTER_EN` undefined: reads are always 0.
- Read-after-write:
  - Word store 0xDEAD_BEEF at RAM_BASE+0x40 with the same-cycle `addr` read.
  - Required: old value in that cycle, 0xDEAD_BEEF in the next.
  - LED write 0x1234_5678 → `led_out`=16'h5678 next cycle, and the read returns 0x0000_5678.
